// File: rtl/counter_pkg.sv
// Shared enums for the up/down mode counter: count modes and control states.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Tick divider: combinational tick on the enabled cycle where the phase reaches prescale.
// Phase register holds while enable is low; clear restarts the phase at zero.
module tick_prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    // >= rather than == so a prescale lowered mid-run cannot strand the phase above it
    always_comb begin
        pre_d = pre_q;
        tick  = 1'b0;
        if (clear) begin
            pre_d = '0;
        end else if (enable) begin
            if (pre_q >= prescale) begin
                tick  = 1'b1;
                pre_d = '0;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/up_down_mode_counter.sv
// Prescaled up/down counter with WRAP/SAT/ONESHOT terminal handling and a one-cycle tc pulse.
// All outputs registered (one cycle after the causing edge); enable low stalls counting only.
module up_down_mode_counter
    import counter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STEP_W = 9,
    parameter int PRE_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              enable,
    input  logic              dir,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic [PRE_W-1:0]  prescale,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              busy,
    output logic              done
);

    // One guard bit over the wider operand so count + step cannot alias past limit
    localparam int SUM_W = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             busy_q, done_q;
    logic             sat_fired_q, sat_fired_d;

    logic             tick;
    logic [SUM_W-1:0] count_x, step_x, limit_x, up_sum;
    logic             terminal;
    logic [WIDTH-1:0] wrap_val, sat_val;

    tick_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable && (state_q == ST_RUN)),
        .clear    (load || start),
        .prescale (prescale),
        .tick     (tick)
    );

    assign count_x  = SUM_W'(count_q);
    assign step_x   = SUM_W'(step);
    assign limit_x  = SUM_W'(limit);
    assign up_sum   = count_x + step_x;
    assign terminal = dir ? (count_x <= step_x) : (up_sum >= limit_x);
    assign wrap_val = dir ? limit : '0;
    assign sat_val  = dir ? '0 : limit;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        tc_d        = 1'b0;
        sat_fired_d = sat_fired_q;
        if (load) begin
            count_d     = load_value;
            sat_fired_d = 1'b0;
        end else if (start) begin
            count_d     = dir ? limit : '0;
            state_d     = ST_RUN;
            sat_fired_d = 1'b0;
        end else if (tick) begin
            if (!terminal) begin
                count_d = dir ? (count_q - step_x[WIDTH-1:0]) : up_sum[WIDTH-1:0];
            end else begin
                case (mode_e'(mode))
                    MODE_SAT: begin
                        // after the first saturation the count simply holds
                        if (!sat_fired_q) begin
                            count_d     = sat_val;
                            tc_d        = 1'b1;
                            sat_fired_d = 1'b1;
                        end
                    end
                    MODE_ONESHOT: begin
                        count_d = sat_val;
                        tc_d    = 1'b1;
                        state_d = ST_DONE;
                    end
                    default: begin
                        count_d = wrap_val;
                        tc_d    = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            tc_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sat_fired_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            tc_q        <= tc_d;
            busy_q      <= (state_d == ST_RUN);
            done_q      <= (state_d == ST_DONE);
            sat_fired_q <= sat_fired_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_up_down_mode_counter.sv
// Directed bench for up_down_mode_counter (WIDTH=8) with an expected-result queue.
module tb_up_down_mode_counter;

    logic       clk = 1'b0;
    logic       rst, start, enable, dir, load;
    logic [1:0] mode;
    logic [8:0] step;
    logic [7:0] limit, prescale, load_value;
    logic [7:0] count;
    logic       tc, busy, done;

    typedef struct packed {
        logic [7:0] count;
        logic       tc;
        logic       busy;
        logic       done;
    } obs_t;

    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    up_down_mode_counter #(.WIDTH(8), .STEP_W(9), .PRE_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .enable     (enable),
        .dir        (dir),
        .mode       (mode),
        .step       (step),
        .limit      (limit),
        .prescale   (prescale),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .tc         (tc),
        .busy       (busy),
        .done       (done)
    );

    // Push the expectation for the inputs currently driven, clock once, then compare.
    task automatic cyc(input logic [7:0] c, input logic t, input logic b, input logic d,
                       input string tag);
        obs_t e, o;
        sb.push_back({c, t, b, d});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        o = {count, tc, busy, done};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: got count=%0d tc=%b busy=%b done=%b, expected count=%0d tc=%b busy=%b done=%b",
                   tag, o.count, o.tc, o.busy, o.done, e.count, e.tc, e.busy, e.done);
        end
    endtask

    initial begin
        logic [7:0] sat_seq [12];
        sat_seq = '{8'd0, 8'd0, 8'd5, 8'd5, 8'd5, 8'd10, 8'd10, 8'd10, 8'd12, 8'd12, 8'd12, 8'd12};

        rst = 1'b1; start = 1'b0; enable = 1'b0; dir = 1'b0; load = 1'b0;
        mode = 2'd0; step = 9'd0; limit = 8'd0; prescale = 8'd0; load_value = 8'd0;
        cyc(8'd0, 1'b0, 1'b0, 1'b0, "reset");

        // up WRAP, step 3, limit 10
        rst = 1'b0; enable = 1'b1; dir = 1'b0; mode = 2'd0; step = 9'd3; limit = 8'd10;
        prescale = 8'd0; start = 1'b1;
        cyc(8'd0, 1'b0, 1'b1, 1'b0, "wrap_start");
        start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            cyc(8'd3, 1'b0, 1'b1, 1'b0, "wrap_3");
            cyc(8'd6, 1'b0, 1'b1, 1'b0, "wrap_6");
            cyc(8'd9, 1'b0, 1'b1, 1'b0, "wrap_9");
            cyc(8'd0, 1'b1, 1'b1, 1'b0, "wrap_tc");
        end

        // down ONESHOT, step 4, limit 10
        dir = 1'b1; mode = 2'd2; step = 9'd4; limit = 8'd10; start = 1'b1;
        cyc(8'd10, 1'b0, 1'b1, 1'b0, "os_start");
        start = 1'b0;
        cyc(8'd6, 1'b0, 1'b1, 1'b0, "os_6");
        cyc(8'd2, 1'b0, 1'b1, 1'b0, "os_2");
        cyc(8'd0, 1'b1, 1'b0, 1'b1, "os_tc");
        for (int i = 0; i < 3; i++) cyc(8'd0, 1'b0, 1'b0, 1'b1, "os_done_hold");
        start = 1'b1;
        cyc(8'd10, 1'b0, 1'b1, 1'b0, "os_rearm");
        start = 1'b0;

        // up SAT, step 5, limit 12, prescale 2
        dir = 1'b0; mode = 2'd1; step = 9'd5; limit = 8'd12; prescale = 8'd2; start = 1'b1;
        cyc(8'd0, 1'b0, 1'b1, 1'b0, "sat_start");
        start = 1'b0;
        for (int i = 0; i < 12; i++)
            cyc(sat_seq[i], (i == 8), 1'b1, 1'b0, "sat_seq");

        // enable dropped mid-prescale freezes count and phase
        mode = 2'd0; step = 9'd1; limit = 8'd100; prescale = 8'd2; start = 1'b1;
        cyc(8'd0, 1'b0, 1'b1, 1'b0, "frz_start");
        start = 1'b0;
        cyc(8'd0, 1'b0, 1'b1, 1'b0, "frz_phase1");
        enable = 1'b0;
        for (int i = 0; i < 5; i++) cyc(8'd0, 1'b0, 1'b1, 1'b0, "frz_hold");
        enable = 1'b1;
        cyc(8'd0, 1'b0, 1'b1, 1'b0, "frz_phase2");
        cyc(8'd1, 1'b0, 1'b1, 1'b0, "frz_tick");
        cyc(8'd1, 1'b0, 1'b1, 1'b0, "frz_after");

        // wide up step: 100 + 200 must be terminal, not wrap to 44
        enable = 1'b0; mode = 2'd1; step = 9'd200; limit = 8'd255; prescale = 8'd0; start = 1'b1;
        cyc(8'd0, 1'b0, 1'b1, 1'b0, "ovf_start");
        start = 1'b0; load = 1'b1; load_value = 8'd100;
        cyc(8'd100, 1'b0, 1'b1, 1'b0, "ovf_load");
        load = 1'b0; enable = 1'b1;
        cyc(8'd255, 1'b1, 1'b1, 1'b0, "ovf_term");
        cyc(8'd255, 1'b0, 1'b1, 1'b0, "ovf_sat_hold");

        // priority: load over start, rst over start
        load = 1'b1; start = 1'b1; load_value = 8'd7;
        cyc(8'd7, 1'b0, 1'b1, 1'b0, "load_over_start_run");
        load = 1'b0; rst = 1'b1;
        cyc(8'd0, 1'b0, 1'b0, 1'b0, "rst_over_start");
        rst = 1'b0; load = 1'b1;
        cyc(8'd7, 1'b0, 1'b0, 1'b0, "load_over_start_idle");
        load = 1'b0; start = 1'b0;

        // limit 0 counting up: every tick terminal
        dir = 1'b0; mode = 2'd0; step = 9'd2; limit = 8'd0; start = 1'b1;
        cyc(8'd0, 1'b0, 1'b1, 1'b0, "lim0_start");
        start = 1'b0;
        cyc(8'd0, 1'b1, 1'b1, 1'b0, "lim0_tc1");
        cyc(8'd0, 1'b1, 1'b1, 1'b0, "lim0_tc2");

        // reserved mode wraps; live step change to 0 holds
        dir = 1'b1; mode = 2'd3; step = 9'd3; limit = 8'd5; start = 1'b1;
        cyc(8'd5, 1'b0, 1'b1, 1'b0, "rsvd_start");
        start = 1'b0;
        cyc(8'd2, 1'b0, 1'b1, 1'b0, "rsvd_2");
        cyc(8'd5, 1'b1, 1'b1, 1'b0, "rsvd_wrap");
        step = 9'd0;
        cyc(8'd5, 1'b0, 1'b1, 1'b0, "step0_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/up_down_mode_counter.md
UP_DOWN_MODE_COUNTER -- requirements
Module: up_down_mode_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, count/limit/load width.
REQ-002 SHALL have parameter STEP_W, default 9, increment width.
REQ-003 SHALL have parameter PRE_W, default 8, prescaler width.
REQ-004 SHALL have clk  input  1  sole clock, rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have start  input  1  pulse: (re)arm counter from start value.
REQ-007 SHALL have enable  input  1  count gate; low freezes counter and prescaler.
REQ-008 SHALL have dir  input  1  0 = up, 1 = down.
REQ-009 SHALL have mode  input  2  0 WRAP, 1 SAT, 2 ONESHOT, 3 reserved (behaves as WRAP).
REQ-010 SHALL have step  input  STEP_W  unsigned amount added/subtracted per tick.
REQ-011 SHALL have limit  input  WIDTH  terminal value (up) / reload value (down).
REQ-012 SHALL have prescale  input  PRE_W  tick every prescale+1 enabled cycles.
REQ-013 SHALL have load, load_value  input  1, WIDTH  synchronous count preset.
REQ-014 SHALL have count  output  WIDTH  registered count.
REQ-015 SHALL have tc  output  1  one-cycle pulse on terminal event.
REQ-016 SHALL have busy  output  1  high in RUN.
REQ-017 SHALL have done  output  1  high in DONE (ONESHOT complete).

Function
REQ-018 SHALL implement states IDLE, RUN, DONE; busy = (RUN), done = (DONE).
REQ-019 Priority SHALL be rst > load > start > tick.
REQ-020 start SHALL set count to 0 (dir=0) or limit (dir=1), clear prescaler, enter RUN from any state, next cycle.
REQ-021 load SHALL set count = load_value, clear prescaler, keep state, suppress tc that cycle.
REQ-022 A tick SHALL occur when state=RUN, enable=1 and prescaler = prescale; prescaler then clears, else increments while enabled.
REQ-023 Up tick: terminal when count + step >= limit, computed at WIDTH+1 bits (no overflow aliasing); else count <= count + step.
REQ-024 Down tick: terminal when count <= step; else count <= count - step.
REQ-025 Terminal, WRAP: count <= 0 (up) / limit (down); stay RUN; tc = 1.
REQ-026 Terminal, SAT: count <= limit (up) / 0 (down); stay RUN; tc = 1 only on the first terminal tick after start/load, further ticks hold count, tc = 0.
REQ-027 Terminal, ONESHOT: count as SAT; go to DONE; tc = 1; DONE ignores ticks until start or rst.
REQ-028 tc SHALL be registered, asserted in the same cycle count shows the terminal-result value.
REQ-029 step = 0: count unchanged per tick; terminal still evaluated (up: count >= limit; down: count = 0).
REQ-030 limit = 0 with dir=0: every tick is terminal.
REQ-031 dir, mode, step, limit, prescale SHALL be sampled live at each tick; changes mid-run need no restart.
REQ-032 enable low SHALL hold count, prescaler and state; start/load still act.

Reset
REQ-033 rst SHALL, at the next clk edge, set state IDLE, count 0, prescaler 0, tc 0, busy 0, done 0, SAT-fired flag 0.
REQ-034 rst mid-RUN or in DONE SHALL abort with no tc pulse; rst together with start/load SHALL win.

Structure
REQ-035 A shared package counter_pkg SHALL hold the mode enum (WRAP/SAT/ONESHOT/RSVD) and state enum (IDLE/RUN/DONE).
REQ-036 Prescaler SHALL be a sub-module tick_prescaler (PRE_W parameter; inputs clk, rst, enable, clear, prescale; output tick).

Verification
REQ-037 WIDTH=8, up, WRAP, step=3, limit=10, prescale=0, start -> count 0,3,6,9,0 with tc on the cycle showing 0, repeating.
REQ-038 Down, ONESHOT, step=4, limit=10 -> count 10,6,2,0; tc once, done=1, busy=0; further enable cycles hold 0; start re-arms to 10.
REQ-039 Up, SAT, step=5, limit=12, prescale=2 -> count changes every 3rd cycle: 0,5,10,12,12; single tc pulse.
REQ-040 WIDTH=8, up, limit=255, step=200, count=100 via load -> terminal detected (300 >= 255), no wrap to 44.
REQ-041 load=1 and start=1 same cycle with load_value=7 -> count 7, state unchanged; rst asserted with start -> IDLE, count 0.
REQ-042 enable toggled low mid-prescale for 5 cycles -> count and prescaler frozen, resume exactly where stopped.
